// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

   // Canonical RISC-V NOP (addi x0, x0, 0), used to fill bubbles in IF/ID.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } ifid_t;

endpackage

// File: rtl/if_next_pc.sv
// Combinational next-PC and priority selection for the fetch stage.
// Priority: misaligned redirect > redirect > (BOOT bubble) > stall > advance.
module if_next_pc
   import if_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  fetch_state_t    i_state,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_stall,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic [XLEN-1:0] o_next_pc,
   output fetch_state_t    o_next_state,
   output logic            o_flush,
   output logic            o_load
);

   logic w_misaligned;

   assign w_misaligned = i_redirect && (i_redirect_pc[1:0] != 2'b00);

   // Select the next PC/state and whether IF/ID takes a bubble or a real fetch.
   always_comb begin
      o_next_pc    = i_pc;
      o_next_state = i_state;
      o_flush      = 1'b0;
      o_load       = 1'b0;
      case (i_state)
         HALT: begin
            // Frozen until reset; keep IF/ID empty.
            o_flush = 1'b1;
         end
         BOOT, RUN: begin
            if (w_misaligned) begin
               o_next_state = HALT;
               o_flush      = 1'b1;
            end else if (i_redirect) begin
               o_next_pc    = i_redirect_pc;
               o_next_state = RUN;
               o_flush      = 1'b1;
            end else if (i_state == BOOT) begin
               // The boot cycle always ends after one edge, even when stalled.
               o_next_state = RUN;
               o_flush      = 1'b1;
            end else if (!i_stall) begin
               o_next_pc = i_pc + XLEN'(4);
               o_load    = 1'b1;
            end
         end
         default: begin
            o_next_state = HALT;
            o_flush      = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch-stage controller: owns the PC, drives the instruction memory address,
// and captures the returned word into the IF/ID pipeline register.
module if_fetch_unit
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter int          XLEN      = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_stall,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   input  logic [XLEN-1:0] i_imem_instr,
   output logic [XLEN-1:0] o_imem_addr,
   output logic [XLEN-1:0] o_id_pc,
   output logic [XLEN-1:0] o_id_instr,
   output logic            o_id_valid,
   output logic            o_halted,
   output logic [31:0]     o_fetch_cnt
);

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_pc;
   ifid_t           r_ifid;
   logic            r_halted;
   logic [31:0]     r_cnt;

   logic [XLEN-1:0] w_next_pc;
   fetch_state_t    w_next_state;
   logic            w_flush;
   logic            w_load;

   if_next_pc #(
      .XLEN (XLEN)
   ) u_next_pc (
      .i_state       (r_state),
      .i_pc          (r_pc),
      .i_stall       (i_stall),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_next_pc     (w_next_pc),
      .o_next_state  (w_next_state),
      .o_flush       (w_flush),
      .o_load        (w_load)
   );

   // FSM, PC, IF/ID and fetch counter; reset wins over any pending redirect/stall.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= BOOT;
         r_pc     <= XLEN'(RESET_VEC);
         r_ifid   <= '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};
         r_halted <= 1'b0;
         r_cnt    <= 32'h0;
      end else begin
         r_state  <= w_next_state;
         r_pc     <= w_next_pc;
         r_halted <= (w_next_state == HALT);
         if (w_flush) begin
            r_ifid <= '{pc: 32'h0, instr: NOP_INSTR, valid: 1'b0};
         end else if (w_load) begin
            r_ifid <= '{pc: 32'(r_pc), instr: 32'(i_imem_instr), valid: 1'b1};
            r_cnt  <= r_cnt + 32'd1;
         end
      end
   end

   assign o_imem_addr = r_pc;
   assign o_id_pc     = XLEN'(r_ifid.pc);
   assign o_id_instr  = XLEN'(r_ifid.instr);
   assign o_id_valid  = r_ifid.valid;
   assign o_halted    = r_halted;
   assign o_fetch_cnt = r_cnt;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus random
// stall/redirect traffic, compared each cycle against a rule-level model.
module tb_if_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_instr;
   logic [31:0] imem_addr;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_valid;
   logic        halted;
   logic [31:0] fetch_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Reference state, derived directly from the fetch rules.
   logic [31:0] m_pc;
   logic        m_boot;
   logic        m_halt;
   logic [31:0] m_id_pc;
   logic [31:0] m_id_instr;
   logic        m_id_valid;
   logic [31:0] m_cnt;

   if_fetch_unit #(
      .RESET_VEC (32'h0000_0000),
      .XLEN      (32)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_stall       (stall),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .i_imem_instr  (imem_instr),
      .o_imem_addr   (imem_addr),
      .o_id_pc       (id_pc),
      .o_id_instr    (id_instr),
      .o_id_valid    (id_valid),
      .o_halted      (halted),
      .o_fetch_cnt   (fetch_cnt)
   );

   always #5 clk = ~clk;

   // Address-tagged memory contents.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h5A00_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".addr"},  imem_addr,         m_pc);
      check({tag, ".idpc"},  id_pc,             m_id_pc);
      check({tag, ".instr"}, id_instr,          m_id_instr);
      check({tag, ".valid"}, {31'b0, id_valid}, {31'b0, m_id_valid});
      check({tag, ".halt"},  {31'b0, halted},   {31'b0, m_halt});
      check({tag, ".cnt"},   fetch_cnt,         m_cnt);
   endtask

   task automatic model_bubble();
      m_id_pc    = 32'h0;
      m_id_instr = NOP;
      m_id_valid = 1'b0;
   endtask

   // Apply one cycle of inputs, advance the model by one edge, compare at negedge.
   task automatic cycle(input string tag, input logic r, input logic s,
                        input logic rd, input logic [31:0] rpc);
      logic [31:0] fetched;
      rst_n       = r;
      stall       = s;
      redirect    = rd;
      redirect_pc = rpc;
      fetched     = mem_word(m_pc);
      if (!r) begin
         m_pc = 32'h0; m_boot = 1'b1; m_halt = 1'b0; m_cnt = 32'h0;
         model_bubble();
      end else if (m_halt) begin
         model_bubble();
      end else if (rd && rpc[1:0] != 2'b00) begin
         m_halt = 1'b1; m_boot = 1'b0;
         model_bubble();
      end else if (rd) begin
         m_pc = rpc; m_boot = 1'b0;
         model_bubble();
      end else if (m_boot) begin
         m_boot = 1'b0;
         model_bubble();
      end else if (!s) begin
         m_id_pc    = m_pc;
         m_id_instr = fetched;
         m_id_valid = 1'b1;
         m_pc       = m_pc + 32'd4;
         m_cnt      = m_cnt + 32'd1;
      end
      @(posedge clk);
      @(negedge clk);
      imem_instr = mem_word(imem_addr);
      check_all(tag);
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      imem_instr = 32'h0;
      m_pc = 32'h0; m_boot = 1'b1; m_halt = 1'b0; m_cnt = 32'h0;
      model_bubble();
      @(negedge clk);

      // Reset for three cycles, then boot and straight-line fetch 0,4,8,12.
      for (int i = 0; i < 3; i++) cycle("reset", 1'b0, 1'b0, 1'b0, 32'h0);
      cycle("boot", 1'b1, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 4; i++) cycle("seq", 1'b1, 1'b0, 1'b0, 32'h0);

      // Stall two cycles at PC=16, then resume.
      cycle("stall", 1'b1, 1'b1, 1'b0, 32'h0);
      cycle("stall", 1'b1, 1'b1, 1'b0, 32'h0);
      cycle("resume", 1'b1, 1'b0, 1'b0, 32'h0);
      cycle("resume", 1'b1, 1'b0, 1'b0, 32'h0);

      // Reach PC=176, then redirect to 785068.
      cycle("jmp176", 1'b1, 1'b0, 1'b1, 32'd176);
      cycle("at176", 1'b1, 1'b0, 1'b1, 32'd785068);
      cycle("tgt", 1'b1, 1'b0, 1'b0, 32'h0);
      cycle("tgt", 1'b1, 1'b0, 1'b0, 32'h0);

      // Redirect and stall together: redirect wins.
      cycle("rd_st", 1'b1, 1'b1, 1'b1, 32'd36);
      cycle("rd_st2", 1'b1, 1'b1, 1'b0, 32'h0);
      cycle("rd_st3", 1'b1, 1'b0, 1'b0, 32'h0);

      // Random aligned traffic.
      for (int i = 0; i < 300; i++) begin
         logic s, rd;
         logic [31:0] t;
         s  = ($urandom_range(0, 3) == 0);
         rd = ($urandom_range(0, 7) == 0);
         t  = $urandom() & 32'hFFFF_FFFC;
         if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8;
         cycle("rand", 1'b1, s, rd, t);
      end

      // Misaligned redirect halts; random traffic is ignored for 10 cycles.
      cycle("mis", 1'b1, 1'b0, 1'b1, 32'h0000_002A);
      for (int i = 0; i < 10; i++)
         cycle("halt", 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom() & 32'hFFFF_FFFC);
      cycle("hrst", 1'b0, 1'b0, 1'b0, 32'h0);
      cycle("boot2", 1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) cycle("seq2", 1'b1, 1'b0, 1'b0, 32'h0);

      // Reset with a redirect pending: redirect must be discarded.
      cycle("rst_rd", 1'b0, 1'b1, 1'b1, 32'h0000_1000);
      cycle("boot3", 1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 2; i++) cycle("seq3", 1'b1, 1'b0, 1'b0, 32'h0);

      // Preload the counter near its top and let it wrap.
      dut.r_cnt = 32'hFFFF_FFFE;
      m_cnt     = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) cycle("wrap", 1'b1, 1'b0, 1'b0, 32'h0);

      // Boot-cycle redirect is honoured.
      cycle("rst4", 1'b0, 1'b0, 1'b0, 32'h0);
      cycle("bootrd", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      for (int i = 0; i < 3; i++) cycle("pcwrap", 1'b1, 1'b0, 1'b0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
